regfile_op_sequencer: RTL

- Multi-cycle operation sequencer that sits around the 4x8-bit register file.
- Accepts one instruction at a time over a valid/ready handshake and drives the register file read addresses (RA1/RA2).
- Captures the read data (RD1/RD2), computes an 8-bit result (single-cycle ALU ops or an iterative 8-cycle multiply), then writes the result back through RA3/WD3/WE3.
- Serves as both the producer of register-file write traffic and the consumer of its read ports.

---
 rtl/regfile_seq_pkg.sv | 32 +++
 rtl/seq_alu8.sv | 52 +++++
 rtl/regfile_op_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_pkg
// Description : Shared widths, opcode and state encodings for the register
//               file operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_seq_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_LDI  = 3'b110,
        OP_SHR1 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu8.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu8
// Description : Combinational single-cycle ALU for the sequencer. MUL is
//               handled by the sequencer and yields zero here.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu8
    import regfile_seq_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] res,
    output logic              carry
);

    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    // Opcode decode; logic ops and LDI leave carry cleared
    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = w_sum[DATA_W-1:0];
                carry = w_sum[DATA_W];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_LDI:  res = imm;
            OP_SHR1: begin
                res   = a >> 1;
                carry = a[0];
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_op_sequencer
// Description : Accepts one instruction at a time, reads two operands from a
//               4x8 register file, executes (ALU or 8-cycle shift-add MUL)
//               and writes the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_op_sequencer
    import regfile_seq_pkg::*;
#(
    parameter logic WE_ACTIVE_LEVEL = 1'b0,
    parameter int   MUL_CYCLES      = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    output logic [ADDR_W-1:0] RA3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    localparam int                CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_e                r_state;
    state_e                w_next_state;
    op_e                   r_op;
    logic [ADDR_W-1:0]     r_rd;
    logic [DATA_W-1:0]     r_imm;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_res;
    logic                  r_cres;
    logic [2*DATA_W-1:0]   r_acc;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]     r_mplier;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_exec_done;
    logic                  w_write;
    logic [2*DATA_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]     w_alu_res;
    logic                  w_alu_carry;
    logic [DATA_W-1:0]     w_exec_res;
    logic                  w_exec_carry;

    seq_alu8 u_alu (
        .op    (r_op),
        .a     (r_a),
        .b     (r_b),
        .imm   (r_imm),
        .res   (w_alu_res),
        .carry (w_alu_carry)
    );

    assign w_accept     = instr_valid && (r_state == ST_IDLE);
    assign w_is_mul     = (r_op == OP_MUL);
    assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_exec_done  = (r_state == ST_EXEC) && (!w_is_mul || (r_cnt == C_CNT_LAST));
    assign w_exec_res   = w_is_mul ? w_acc_next[DATA_W-1:0] : w_alu_res;
    assign w_exec_carry = w_is_mul ? (w_acc_next[2*DATA_W-1:DATA_W] != '0) : w_alu_carry;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; EXEC holds for MUL until the last iteration
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_READ;
            ST_READ:  w_next_state = ST_EXEC;
            ST_EXEC:  if (w_exec_done) w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode; reset suppresses the write so an aborted op never commits
    always_comb begin
        instr_ready = (r_state == ST_IDLE);
        w_write     = (r_state == ST_WRITE) && !reset;
        done        = w_write;
        WE3         = w_write ? WE_ACTIVE_LEVEL : ~WE_ACTIVE_LEVEL;
    end

    // Datapath: instruction latch, operand capture, MUL iteration, write-back
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cres   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            RA1      <= '0;
            RA2      <= '0;
            RA3      <= '0;
            WD3      <= '0;
            result   <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(instr_op);
                r_rd  <= instr_rd;
                r_imm <= instr_imm;
                RA1   <= instr_rs1;
                RA2   <= instr_rs2;
            end
            if (r_state == ST_READ) begin
                r_a      <= RD1;
                r_b      <= RD2;
                r_acc    <= '0;
                r_mcand  <= {{DATA_W{1'b0}}, RD1};
                r_mplier <= RD2;
                r_cnt    <= '0;
            end
            if ((r_state == ST_EXEC) && w_is_mul) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_exec_done) begin
                r_res  <= w_exec_res;
                r_cres <= w_exec_carry;
                RA3    <= r_rd;
                WD3    <= w_exec_res;
            end
            if (r_state == ST_WRITE) begin
                result <= r_res;
                zero   <= (r_res == '0);
                carry  <= r_cres;
            end
        end
    end

endmodule
`default_nettype wire
